// File: rtl/pe_stream_tx_pkg.sv
// Shared definitions for the PE stream transmitter: FSM encoding and default widths.
package pe_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_STREAM   = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_PARA_WIDTH = 8;
    localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/pe_stream_tx_skid.sv
// Two-entry in-order skid buffer with flow-through: an incoming word is visible
// at the head in the same cycle when the buffer holds nothing older.
module pe_stream_tx_skid
    import pe_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  stored;
    logic                  wr_store;
    logic                  rd_store;

    assign stored = (count_q != 2'd0);
    assign valid  = stored || push;
    assign head   = stored ? mem_q[rd_ptr_q] : push_data;

    // A word popped straight off the input never touches storage.
    assign wr_store = push && !(pop && !stored);
    assign rd_store = pop && stored;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_store) wr_ptr_q <= ~wr_ptr_q;
            if (rd_store) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, wr_store} - {1'b0, rd_store};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;

endmodule

// File: rtl/pe_stream_tx.sv
// Streams len words from a source buffer to a PE input FIFO under backpressure.
// Optional stall counter enabled by defining PE_STREAM_TX_STALL_CNT_EN.
module pe_stream_tx
    import pe_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PARA_WIDTH = DEF_PARA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [PARA_WIDTH-1:0]  len,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    input  logic                   pe_fifo_full,
    output logic                   start_load,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_en,
    output logic                   busy,
    output logic                   done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [PARA_WIDTH-1:0] ONE_P = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

    state_t                state_q, state_d;
    logic [PARA_WIDTH-1:0] len_q;
    logic [PARA_WIDTH-1:0] issued_q;
    logic [PARA_WIDTH-1:0] sent_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_vld_p1;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [1:0]            buf_count;
    logic                  accept;
    logic                  issue;
    logic                  last_word;

    assign accept = (state_q == ST_IDLE) && start;

    // Outstanding = stored words plus the read whose data lands next cycle.
    assign issue = (state_q == ST_STREAM)
                && (({1'b0, buf_count} + {2'b00, rd_vld_p1}) < 3'd2)
                && (issued_q < len_q);

    assign data_en   = buf_valid && !pe_fifo_full;
    assign last_word = data_en && ((sent_q + ONE_P) == len_q);

    pe_stream_tx_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst_n),
        .push      (rd_vld_p1),
        .push_data (mem_rd_data),
        .pop       (data_en),
        .valid     (buf_valid),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (len == '0) ? ST_FINISH : ST_ANNOUNCE;
            end
            ST_ANNOUNCE: state_d = ST_STREAM;
            ST_STREAM: begin
                if (last_word) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // p0: read issue / p1: read data returns into the skid buffer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            rd_addr_q <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_vld_p1 <= issue;
            if (accept) begin
                len_q     <= len;
                rd_addr_q <= base_addr;
                issued_q  <= '0;
                sent_q    <= '0;
            end else begin
                if (issue) begin
                    issued_q  <= issued_q + ONE_P;
                    rd_addr_q <= rd_addr_q + ONE_A;
                end
                if (data_en) sent_q <= sent_q + ONE_P;
            end
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_addr_q;
    assign start_load  = (state_q == ST_ANNOUNCE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign data_out    = buf_valid ? buf_head : '0;

`ifdef PE_STREAM_TX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (buf_valid && pe_fifo_full && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_stream_tx.sv
// Scoreboard bench for pe_stream_tx: expected words/addresses queued at stimulus, checked by a monitor.
module tb_pe_stream_tx;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int PW = 8;
`ifdef PE_STREAM_TX_STALL_CNT_EN
    localparam int STALL_EN = 1;
`else
    localparam int STALL_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [PW-1:0] len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          pe_fifo_full = 1'b0;
    logic          start_load;
    logic [DW-1:0] data_out;
    logic          data_en;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    pe_stream_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .pe_fifo_full (pe_fifo_full),
        .start_load   (start_load),
        .data_out     (data_out),
        .data_en      (data_en),
        .busy         (busy),
        .done         (done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Source buffer: mem[a] = a, one-cycle read latency
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? {{(DW-AW){1'b0}}, mem_rd_addr} : 16'hDEAD;
    end

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words_seen, sl_cnt, rd_cnt, sl_cyc, first_en_cyc, last_en_cyc, done_cyc;
    bit done_seen;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n == 1'b0) begin
            if (start_load) begin
                sl_cnt++;
                sl_cyc = cyc;
            end
            if (mem_rd_en) begin
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_addr: got unexpected read at %0h expected none", mem_rd_addr);
                end else begin
                    chk("read_addr", {24'h0, mem_rd_addr}, {24'h0, addr_q.pop_front()});
                end
            end
            if (data_en) begin
                chk("en_while_full", {31'h0, pe_fifo_full}, 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_out: got extra word %0h expected none", data_out);
                end else begin
                    chk("data_out", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
                end
                if (words_seen == 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                words_seen++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("busy_at_done", {31'h0, busy}, 32'h1);
            end
        end
    end

    task automatic prep(input logic [AW-1:0] b, input logic [PW-1:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back({{(DW-AW){1'b0}}, a});
        end
        words_seen = 0;
        sl_cnt     = 0;
        rd_cnt     = 0;
        done_seen  = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'h55; len = 8'd7;
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [PW-1:0] n,
                            input int stall_after, input int stall_len, input int restart_k,
                            input logic [15:0] exp_stall, input bit check_tput);
        int bp_left;
        bit bp_done;
        bp_left = 0;
        bp_done = 1'b0;
        prep(b, n);
        for (int k = 0; k < 300 && !done_seen; k++) begin
            @(posedge clk); #1;
            if (bp_left > 0) begin
                bp_left--;
                if (bp_left == 0) pe_fifo_full = 1'b0;
            end else if (!bp_done && stall_after > 0 && words_seen == stall_after) begin
                pe_fifo_full = 1'b1;
                bp_left = stall_len;
                bp_done = 1'b1;
            end
            if (k == restart_k) begin
                start = 1'b1; base_addr = 8'h80; len = 8'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        pe_fifo_full = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done for len %0d", n);
        end
        chk("start_load_pulses", sl_cnt, (n != 0) ? 32'd1 : 32'd0);
        chk("read_count", rd_cnt, {24'h0, n});
        chk("word_count", words_seen, {24'h0, n});
        chk("words_left", exp_q.size(), 32'd0);
        chk("addrs_left", addr_q.size(), 32'd0);
        if (n != 0) chk("done_after_last", done_cyc - last_en_cyc, 32'd1);
        if (check_tput) begin
            chk("first_en_latency", first_en_cyc - sl_cyc, 32'd2);
            chk("consecutive_en", last_en_cyc - first_en_cyc, {24'h0, n} - 32'd1);
        end
        chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, exp_stall});
        chk("done_low_after", {31'h0, done}, 32'h0);
        chk("busy_idle_after", {31'h0, busy}, 32'h0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},      {31'h0, mem_rd_en}, 32'h0);
        chk({tag, "_start_load"}, {31'h0, start_load}, 32'h0);
        chk({tag, "_data_en"},    {31'h0, data_en}, 32'h0);
        chk({tag, "_busy"},       {31'h0, busy}, 32'h0);
        chk({tag, "_done"},       {31'h0, done}, 32'h0);
        chk({tag, "_rd_addr"},    {24'h0, mem_rd_addr}, 32'h0);
        chk({tag, "_data_out"},   {16'h0, data_out}, 32'h0);
        chk({tag, "_stall_cnt"},  {16'h0, stall_cnt}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b0;

        // Nominal stream, no backpressure
        run_xfer(8'h10, 8'd6, 0, 0, -1, 16'd0, 1'b1);
        // Backpressure for 3 cycles after word 2
        run_xfer(8'h10, 8'd6, 2, 3, -1, (STALL_EN != 0) ? 16'd3 : 16'd0, 1'b0);
        // Zero-length transfer
        run_xfer(8'h33, 8'd0, 0, 0, -1, 16'd0, 1'b0);
        // Address wrap
        run_xfer(8'hFE, 8'd4, 0, 0, -1, 16'd0, 1'b1);
        // Start pulsed again mid-stream
        run_xfer(8'h30, 8'd6, 0, 0, 3, 16'd0, 1'b1);

        // Reset mid-transfer after word 3
        prep(8'h20, 8'd10);
        for (int k = 0; k < 100 && words_seen < 3; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("reset_mid_word3", words_seen, 32'd3);
        chk_reset_outputs("midreset");
        run_xfer(8'h40, 8'd2, 0, 0, -1, 16'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
